// File: rtl/trap_pkg.sv
// Shared encodings for the machine-mode trap sequencer: FSM states, PC-source
// selects, mcause codes and the SYSTEM-instruction fields used to decode ecall/ebreak/mret.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } trap_state_t;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_NEXT = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_EPC  = 2'b11;

  localparam int unsigned CAUSE_INT_EXT          = 11;
  localparam int unsigned CAUSE_INT_SW           = 3;
  localparam int unsigned CAUSE_INT_TIMER        = 7;
  localparam int unsigned CAUSE_ILLEGAL          = 2;
  localparam int unsigned CAUSE_MISALIGNED_INSTR = 0;
  localparam int unsigned CAUSE_ECALL            = 11;
  localparam int unsigned CAUSE_EBREAK           = 3;
  localparam int unsigned CAUSE_MISALIGNED_STORE = 6;
  localparam int unsigned CAUSE_MISALIGNED_LOAD  = 4;

  localparam logic [4:0] SYSTEM_OPCODE = 5'b11100;
  localparam logic [4:0] ECALL_RS2     = 5'd0;
  localparam logic [4:0] EBREAK_RS2    = 5'd1;
  localparam logic [4:0] MRET_RS2      = 5'd2;
  localparam logic [6:0] MRET_FUNCT7   = 7'b0011000;

endpackage

// File: rtl/trap_priority_enc.sv
// Fixed-priority selection among pending interrupts and synchronous exceptions;
// yields the trap request plus the interrupt flag and cause code of the winner.
module trap_priority_enc
  import trap_pkg::*;
#(
  parameter int unsigned CAUSE_W = 4
) (
  input  logic               eip_in,
  input  logic               sip_in,
  input  logic               tip_in,
  input  logic               illegal_in,
  input  logic               misaligned_instr_in,
  input  logic               misaligned_load_in,
  input  logic               misaligned_store_in,
  input  logic               ecall_in,
  input  logic               ebreak_in,
  output logic               trap_req_c,
  output logic               i_or_e_c,
  output logic [CAUSE_W-1:0] cause_c
);

  always_comb begin
    trap_req_c = 1'b1;
    i_or_e_c   = 1'b0;
    cause_c    = '0;
    if (eip_in) begin
      i_or_e_c = 1'b1;
      cause_c  = CAUSE_W'(CAUSE_INT_EXT);
    end else if (sip_in) begin
      i_or_e_c = 1'b1;
      cause_c  = CAUSE_W'(CAUSE_INT_SW);
    end else if (tip_in) begin
      i_or_e_c = 1'b1;
      cause_c  = CAUSE_W'(CAUSE_INT_TIMER);
    end else if (illegal_in) begin
      cause_c = CAUSE_W'(CAUSE_ILLEGAL);
    end else if (misaligned_instr_in) begin
      cause_c = CAUSE_W'(CAUSE_MISALIGNED_INSTR);
    end else if (ecall_in) begin
      cause_c = CAUSE_W'(CAUSE_ECALL);
    end else if (ebreak_in) begin
      cause_c = CAUSE_W'(CAUSE_EBREAK);
    end else if (misaligned_store_in) begin
      cause_c = CAUSE_W'(CAUSE_MISALIGNED_STORE);
    end else if (misaligned_load_in) begin
      cause_c = CAUSE_W'(CAUSE_MISALIGNED_LOAD);
    end else begin
      trap_req_c = 1'b0;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret return sequencer driving PC select, flush and CSR strobes.
// Optional build macro TRAP_VECTORED_EN adds vec_mode_in / vec_offset_out for vectored mtvec.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CAUSE_W      = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               illegal_instr_in,
  input  logic               misaligned_instr_in,
  input  logic               misaligned_load_in,
  input  logic               misaligned_store_in,
  input  logic [4:0]         opcode_6_to_2_in,
  input  logic [2:0]         funct3_in,
  input  logic [6:0]         funct7_in,
  input  logic [4:0]         rs1_adder_in,
  input  logic [4:0]         rs2_adder_in,
  input  logic [4:0]         rd_adder_in,
  input  logic [2:0]         irq_in,
  input  logic [2:0]         ip_in,
  input  logic [2:0]         ie_in,
  input  logic               mie_in,
`ifdef TRAP_VECTORED_EN
  input  logic               vec_mode_in,
  output logic [5:0]         vec_offset_out,
`endif
  output logic [1:0]         pc_src_out,
  output logic               flush_out,
  output logic               instret_inc_out,
  output logic               set_epc_out,
  output logic               set_cause_out,
  output logic               mie_clear_out,
  output logic               mie_set_out,
  output logic               trap_taken_out,
  output logic               i_or_e_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic               misaligned_exception_out
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

  trap_state_t        state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               sys_base, ecall, ebreak, mret;
  logic [2:0]         irq_pend;
  logic               trap_req_c, i_or_e_c;
  logic [CAUSE_W-1:0] cause_c;
  logic               dwell_first, dwell_last;

  // SYSTEM-instruction decode; the three encodings differ only in rs2/funct7.
  assign sys_base = (opcode_6_to_2_in == SYSTEM_OPCODE) && (rs1_adder_in == 5'd0) &&
                    (rd_adder_in == 5'd0) && (funct3_in == 3'd0);
  assign ecall    = sys_base && (rs2_adder_in == ECALL_RS2)  && (funct7_in == 7'd0);
  assign ebreak   = sys_base && (rs2_adder_in == EBREAK_RS2) && (funct7_in == 7'd0);
  assign mret     = sys_base && (rs2_adder_in == MRET_RS2)   && (funct7_in == MRET_FUNCT7);

  // Bit order {external, timer, software}; globally masked by mstatus.MIE.
  assign irq_pend = {3{mie_in}} & ie_in & (irq_in | ip_in);

  trap_priority_enc #(.CAUSE_W(CAUSE_W)) u_prio (
    .eip_in              (irq_pend[2]),
    .sip_in              (irq_pend[0]),
    .tip_in              (irq_pend[1]),
    .illegal_in          (illegal_instr_in),
    .misaligned_instr_in (misaligned_instr_in),
    .misaligned_load_in  (misaligned_load_in),
    .misaligned_store_in (misaligned_store_in),
    .ecall_in            (ecall),
    .ebreak_in           (ebreak),
    .trap_req_c          (trap_req_c),
    .i_or_e_c            (i_or_e_c),
    .cause_c             (cause_c)
  );

  assign dwell_first = (cnt == CNT_W'(FLUSH_CYCLES));
  assign dwell_last  = (cnt <= CNT_W'(1));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state                    <= ST_RESET;
      cnt                      <= '0;
      cause_out                <= '0;
      i_or_e_out               <= 1'b0;
      misaligned_exception_out <= 1'b0;
`ifdef TRAP_VECTORED_EN
      vec_offset_out           <= '0;
`endif
    end else begin
      state                    <= state_nxt;
      cnt                      <= cnt_nxt;
      misaligned_exception_out <= misaligned_instr_in | misaligned_load_in | misaligned_store_in;
      if (trap_taken_out) begin
        cause_out  <= cause_c;
        i_or_e_out <= i_or_e_c;
`ifdef TRAP_VECTORED_EN
        vec_offset_out <= (i_or_e_c && vec_mode_in) ? 6'({cause_c, 2'b00}) : '0;
`endif
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    pc_src_out      = PC_BOOT;
    flush_out       = 1'b0;
    instret_inc_out = 1'b0;
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    trap_taken_out  = 1'b0;
    case (state)
      ST_RESET: begin
        flush_out = 1'b1;
        state_nxt = ST_OPERATING;
      end
      ST_OPERATING: begin
        pc_src_out      = PC_NEXT;
        instret_inc_out = 1'b1;
        if (trap_req_c) begin
          trap_taken_out  = 1'b1;
          instret_inc_out = 1'b0;
          cnt_nxt         = CNT_W'(FLUSH_CYCLES);
          state_nxt       = ST_TRAP_TAKEN;
        end else if (mret) begin
          instret_inc_out = 1'b0;
          cnt_nxt         = CNT_W'(FLUSH_CYCLES);
          state_nxt       = ST_TRAP_RETURN;
        end
      end
      ST_TRAP_TAKEN: begin
        pc_src_out    = PC_TRAP;
        flush_out     = 1'b1;
        set_epc_out   = dwell_first;
        set_cause_out = dwell_first;
        mie_clear_out = dwell_first;
        cnt_nxt       = dwell_last ? '0 : cnt - CNT_W'(1);
        if (dwell_last) state_nxt = ST_OPERATING;
      end
      ST_TRAP_RETURN: begin
        pc_src_out  = PC_EPC;
        flush_out   = 1'b1;
        mie_set_out = dwell_first;
        cnt_nxt     = dwell_last ? '0 : cnt - CNT_W'(1);
        if (dwell_last) state_nxt = ST_OPERATING;
      end
      default: state_nxt = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized self-checking bench for trap_sequencer against a cycle-level reference model.
// Build with TRAP_VECTORED_EN defined to also check vec_offset_out.
module tb_trap_sequencer;

  localparam int unsigned FLUSH = 2;
  localparam int unsigned CW    = 4;

  typedef struct packed {
    logic       rst;
    logic       ill, mis_i, mis_l, mis_s;
    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] irq, ip, ie;
    logic       mie;
    logic       vec;
  } stim_t;

  stim_t nx, cur;
  logic clk_in = 1'b0;

  logic [1:0]    pc_src_out;
  logic          flush_out, instret_inc_out, set_epc_out, set_cause_out;
  logic          mie_clear_out, mie_set_out, trap_taken_out, i_or_e_out;
  logic [CW-1:0] cause_out;
  logic          misaligned_exception_out;
`ifdef TRAP_VECTORED_EN
  logic [5:0]    vec_offset_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_boot;
  int m_left;
  bit m_ret, m_first;
  int m_cause;
  bit m_intr, m_mis;
  int m_vec;

  always #5 clk_in = ~clk_in;

  trap_sequencer #(.FLUSH_CYCLES(FLUSH), .CAUSE_W(CW)) dut (
    .clk_in                   (clk_in),
    .rst_in                   (cur.rst),
    .illegal_instr_in         (cur.ill),
    .misaligned_instr_in      (cur.mis_i),
    .misaligned_load_in       (cur.mis_l),
    .misaligned_store_in      (cur.mis_s),
    .opcode_6_to_2_in         (cur.op),
    .funct3_in                (cur.f3),
    .funct7_in                (cur.f7),
    .rs1_adder_in             (cur.rs1),
    .rs2_adder_in             (cur.rs2),
    .rd_adder_in              (cur.rd),
    .irq_in                   (cur.irq),
    .ip_in                    (cur.ip),
    .ie_in                    (cur.ie),
    .mie_in                   (cur.mie),
`ifdef TRAP_VECTORED_EN
    .vec_mode_in              (cur.vec),
    .vec_offset_out           (vec_offset_out),
`endif
    .pc_src_out               (pc_src_out),
    .flush_out                (flush_out),
    .instret_inc_out          (instret_inc_out),
    .set_epc_out              (set_epc_out),
    .set_cause_out            (set_cause_out),
    .mie_clear_out            (mie_clear_out),
    .mie_set_out              (mie_set_out),
    .trap_taken_out           (trap_taken_out),
    .i_or_e_out               (i_or_e_out),
    .cause_out                (cause_out),
    .misaligned_exception_out (misaligned_exception_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_word(input stim_t s);
    return {s.f7, s.rs2, s.rs1, s.f3, s.rd, s.op, 2'b11};
  endfunction

  // Walk the cause table in priority order; first active source wins.
  function automatic void prio(input stim_t s, output bit req, output bit intr, output int code);
    int  codes [9] = '{11, 3, 7, 2, 0, 11, 3, 6, 4};
    bit  hit   [9];
    logic [31:0] w;
    w = instr_word(s);
    hit[0] = s.mie & s.ie[2] & (s.irq[2] | s.ip[2]);
    hit[1] = s.mie & s.ie[0] & (s.irq[0] | s.ip[0]);
    hit[2] = s.mie & s.ie[1] & (s.irq[1] | s.ip[1]);
    hit[3] = s.ill;
    hit[4] = s.mis_i;
    hit[5] = (w == 32'h0000_0073);
    hit[6] = (w == 32'h0010_0073);
    hit[7] = s.mis_s;
    hit[8] = s.mis_l;
    req = 1'b0; intr = 1'b0; code = 0;
    for (int i = 8; i >= 0; i--) begin
      if (hit[i]) begin
        req = 1'b1; intr = (i < 3); code = codes[i];
      end
    end
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_left = 0; m_ret = 1'b0; m_first = 1'b0;
    m_cause = 0; m_intr = 1'b0; m_mis = 1'b0; m_vec = 0;
  endtask

  // One clock: apply staged stimulus, check outputs mid-cycle, advance the model.
  task automatic run_cycle();
    bit req, intr, mret;
    int code;
    int e_pc;
    bit e_flush, e_inst, e_taken, e_entry_strobe, e_mie_set;
    @(posedge clk_in);
    #1;
    cur = nx;
    @(negedge clk_in);
    prio(cur, req, intr, code);
    mret = (instr_word(cur) == 32'h3020_0073);
    e_taken = 1'b0; e_entry_strobe = 1'b0; e_mie_set = 1'b0; e_inst = 1'b0;
    if (m_boot) begin
      e_pc = 0; e_flush = 1'b1;
    end else if (m_left > 0) begin
      e_pc = m_ret ? 3 : 2; e_flush = 1'b1;
      e_entry_strobe = !m_ret && m_first;
      e_mie_set      = m_ret && m_first;
    end else begin
      e_pc = 1; e_flush = 1'b0;
      e_taken = req;
      e_inst  = !req && !mret;
    end
    chk("pc_src",      32'(pc_src_out),               32'(e_pc));
    chk("flush",       32'(flush_out),                32'(e_flush));
    chk("instret_inc", 32'(instret_inc_out),          32'(e_inst));
    chk("trap_taken",  32'(trap_taken_out),           32'(e_taken));
    chk("set_epc",     32'(set_epc_out),              32'(e_entry_strobe));
    chk("set_cause",   32'(set_cause_out),            32'(e_entry_strobe));
    chk("mie_clear",   32'(mie_clear_out),            32'(e_entry_strobe));
    chk("mie_set",     32'(mie_set_out),              32'(e_mie_set));
    chk("cause",       32'(cause_out),                32'(m_cause));
    chk("i_or_e",      32'(i_or_e_out),               32'(m_intr));
    chk("misaligned",  32'(misaligned_exception_out), 32'(m_mis));
`ifdef TRAP_VECTORED_EN
    chk("vec_offset",  32'(vec_offset_out),           32'(m_vec));
`endif
    if (!cur.rst) begin
      model_reset();
    end else begin
      m_mis = cur.mis_i | cur.mis_l | cur.mis_s;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_left > 0) begin
        m_left--; m_first = 1'b0;
      end else if (req) begin
        m_cause = code; m_intr = intr; m_vec = (intr && cur.vec) ? code * 4 : 0;
        m_left = FLUSH; m_ret = 1'b0; m_first = 1'b1;
      end else if (mret) begin
        m_left = FLUSH; m_ret = 1'b1; m_first = 1'b1;
      end
    end
  endtask

  task automatic set_idle();
    nx = '0;
    nx.rst = 1'b1;
  endtask

  task automatic set_sys(input logic [4:0] rs2, input logic [6:0] f7);
    nx.op = 5'b11100; nx.f3 = 3'd0; nx.rs1 = 5'd0; nx.rd = 5'd0;
    nx.rs2 = rs2; nx.f7 = f7;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic rand_stim();
    int k;
    set_idle();
    nx.rst = ($urandom_range(0, 59) != 0);
    k = $urandom_range(0, 9);
    case (k)
      0: set_sys(5'd0, 7'd0);
      1: set_sys(5'd1, 7'd0);
      2, 3: set_sys(5'd2, 7'b0011000);
      4: set_sys(5'd2, 7'b0011000 ^ 7'(1 << $urandom_range(0, 6)));
      default: begin
        nx.op = 5'($urandom); nx.f3 = 3'($urandom); nx.f7 = 7'($urandom);
        nx.rs1 = 5'($urandom); nx.rs2 = 5'($urandom); nx.rd = 5'($urandom);
      end
    endcase
    nx.ill   = ($urandom_range(0, 11) == 0);
    nx.mis_i = ($urandom_range(0, 11) == 0);
    nx.mis_l = ($urandom_range(0, 9) == 0);
    nx.mis_s = ($urandom_range(0, 9) == 0);
    if ($urandom_range(0, 5) == 0) nx.irq = 3'($urandom);
    if ($urandom_range(0, 7) == 0) nx.ip  = 3'($urandom);
    nx.ie  = 3'($urandom);
    nx.mie = 1'($urandom);
    nx.vec = 1'($urandom);
  endtask

  initial begin
    set_idle();
    nx.rst = 1'b0;
    cur = nx;
    repeat (2) @(posedge clk_in);
    model_reset();

    // Reset held, then released: one boot cycle before normal fetch
    nx.rst = 1'b0;
    run_cycle(); run_cycle();
    idle_cycles(3);

    // ecall
    set_idle(); set_sys(5'd0, 7'd0); run_cycle();
    idle_cycles(3);

    // Software + timer interrupt, then same with global enable cleared
    set_idle(); nx.mie = 1'b1; nx.ie = 3'b111; nx.irq = 3'b011; run_cycle();
    idle_cycles(3);
    set_idle(); nx.mie = 1'b0; nx.ie = 3'b111; nx.irq = 3'b011; run_cycle(); run_cycle();

    // mret with illegal, then mret alone
    set_idle(); set_sys(5'd2, 7'b0011000); nx.ill = 1'b1; run_cycle();
    idle_cycles(3);
    set_idle(); set_sys(5'd2, 7'b0011000); run_cycle();
    idle_cycles(3);

    // External interrupt in vectored mode, then an exception
    set_idle(); nx.mie = 1'b1; nx.ie = 3'b100; nx.irq = 3'b100; nx.vec = 1'b1; run_cycle();
    idle_cycles(3);
    set_idle(); nx.ill = 1'b1; nx.vec = 1'b1; run_cycle();
    idle_cycles(3);

    // Misaligned load pulse, then reset mid-dwell
    set_idle(); nx.mis_l = 1'b1; run_cycle();
    idle_cycles(1);
    set_idle(); nx.rst = 1'b0; run_cycle();
    idle_cycles(3);

    for (int i = 0; i < 4000; i++) begin
      rand_stim();
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
